// File: rtl/mvm_par_pkg.sv
// Shared state type, accumulator sizing and pipeline depth for the parallel MVM engine.
// Build option: MVM_PIPE_MULT_EN adds a second multiplier register stage.
package mvm_par_pkg;

    typedef enum logic [2:0] {
        StLoadA,
        StLoadX,
        StCompute,
        StDrain,
        StOutput
    } mvm_state_t;

`ifdef MVM_PIPE_MULT_EN
    localparam int unsigned PIPE_DEPTH = 4;
`else
    localparam int unsigned PIPE_DEPTH = 3;
`endif

    function automatic int unsigned acc_width(input int unsigned b, input int unsigned k);
        return 2 * b + $clog2(k);
    endfunction

endpackage

// File: rtl/mvm_par_lane.sv
// One MAC lane: private A bank, broadcast X copy, multiply pipeline and accumulator.
// Build option: MVM_PIPE_MULT_EN inserts an extra product register stage.
module mvm_par_lane
    import mvm_par_pkg::*;
#(
    parameter int unsigned K     = 8,
    parameter int unsigned P     = 2,
    parameter int unsigned B     = 8,
    parameter int unsigned ACC_W = 2 * B + $clog2(K),
    parameter int unsigned AW    = $clog2(K * K / P),
    parameter int unsigned KW    = $clog2(K),
    parameter int unsigned GW    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_we_i,
    input  logic [AW-1:0]           a_waddr_i,
    input  logic                    x_we_i,
    input  logic [KW-1:0]           x_waddr_i,
    input  logic signed [B-1:0]     wdata_i,
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    input  logic [KW-1:0]           rd_col_i,
    input  logic                    rd_first_i,
    input  logic                    rd_last_i,
    input  logic [GW-1:0]           rd_grp_i,
    output logic                    wb_valid_o,
    output logic [GW-1:0]           wb_grp_o,
    output logic signed [ACC_W-1:0] wb_acc_o
);

    logic signed [B-1:0] a_mem [K*K/P];
    logic signed [B-1:0] x_mem [K];

    logic                  v1_q, first1_q, last1_q;
    logic [GW-1:0]         grp1_q;
    logic signed [B-1:0]   a_rd_q, x_rd_q;
    logic                  v2_q, first2_q, last2_q;
    logic [GW-1:0]         grp2_q;
    logic signed [2*B-1:0] prod_q;

    logic                  pv, pfirst, plast;
    logic [GW-1:0]         pgrp;
    logic signed [2*B-1:0] pprod;

    logic signed [ACC_W-1:0] prod_ext, acc_q, acc_d;

    always_ff @(posedge clk) begin
        if (a_we_i) a_mem[a_waddr_i] <= wdata_i;
        if (x_we_i) x_mem[x_waddr_i] <= wdata_i;
        a_rd_q   <= a_mem[rd_addr_i];
        x_rd_q   <= x_mem[rd_col_i];
        first1_q <= rd_first_i;
        last1_q  <= rd_last_i;
        grp1_q   <= rd_grp_i;
        prod_q   <= (2 * B)'(a_rd_q) * (2 * B)'(x_rd_q);
        first2_q <= first1_q;
        last2_q  <= last1_q;
        grp2_q   <= grp1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= rd_en_i;
            v2_q <= v1_q;
        end
    end

`ifdef MVM_PIPE_MULT_EN
    logic                  v3_q, first3_q, last3_q;
    logic [GW-1:0]         grp3_q;
    logic signed [2*B-1:0] prod2_q;

    always_ff @(posedge clk) begin
        prod2_q  <= prod_q;
        first3_q <= first2_q;
        last3_q  <= last2_q;
        grp3_q   <= grp2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) v3_q <= 1'b0;
        else       v3_q <= v2_q;
    end

    assign pv     = v3_q;
    assign pfirst = first3_q;
    assign plast  = last3_q;
    assign pgrp   = grp3_q;
    assign pprod  = prod2_q;
`else
    assign pv     = v2_q;
    assign pfirst = first2_q;
    assign plast  = last2_q;
    assign pgrp   = grp2_q;
    assign pprod  = prod_q;
`endif

    assign prod_ext = {{(ACC_W - 2 * B){pprod[2*B-1]}}, pprod};

    // Column 0 loads the product directly so row groups run back-to-back.
    always_comb begin
        acc_d = acc_q;
        if (pv) acc_d = pfirst ? prod_ext : acc_q + prod_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign wb_valid_o = pv && plast;
    assign wb_grp_o   = pgrp;
    assign wb_acc_o   = acc_d;

endmodule

// File: rtl/mvm_par_engine.sv
// Parallel matrix-vector engine: load FSM, P MAC lanes, Y register file and result stream.
// Build option: MVM_PIPE_MULT_EN lengthens the lane pipeline and drain by one cycle.
module mvm_par_engine
    import mvm_par_pkg::*;
#(
    parameter int unsigned K      = 8,
    parameter int unsigned P      = 2,
    parameter int unsigned B      = 8,
    localparam int unsigned ACC_W = acc_width(B, K),
    localparam int unsigned KW    = $clog2(K)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [B-1:0]     in_data_i,
    input  logic                    mat_keep_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [ACC_W-1:0] out_data_o,
    output logic [KW-1:0]           out_index_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned N  = K * K / P;
    localparam int unsigned G  = K / P;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned LW = (P > 1) ? $clog2(P) : 1;

    if (K < 2 || (K % P) != 0) begin : g_bad_cfg
        $error("mvm_par_engine: K must be >= 2 and a multiple of P");
    end

    mvm_state_t    state_q, state_d;
    logic [KW-1:0] a_col_q, a_col_d, x_cnt_q, x_cnt_d, c_col_q, c_col_d, o_idx_q, o_idx_d;
    logic [LW-1:0] a_lane_q, a_lane_d;
    logic [AW-1:0] a_base_q, a_base_d, c_addr_q, c_addr_d;
    logic [GW-1:0] c_grp_q, c_grp_d;
    logic [2:0]    drain_q, drain_d;
    logic          done_q, done_d;
    logic          in_hs, out_hs;

    logic signed [ACC_W-1:0] y_q [K];
    logic signed [ACC_W-1:0] lane_acc [P];
    logic [GW-1:0]           lane_grp [P];
    logic                    lane_wb [P];
    logic [KW-1:0]           wb_row [P];

    assign in_ready_o  = (state_q == StLoadA) || (state_q == StLoadX);
    assign out_valid_o = (state_q == StOutput);
    assign busy_o      = (state_q == StCompute) || (state_q == StDrain) || (state_q == StOutput);
    assign out_data_o  = out_valid_o ? y_q[o_idx_q] : '0;
    assign out_index_o = o_idx_q;
    assign done_o      = done_q;
    assign in_hs       = in_valid_i && in_ready_o;
    assign out_hs      = out_valid_o && out_ready_i;

    always_comb begin
        state_d  = state_q;
        a_col_d  = a_col_q;
        a_lane_d = a_lane_q;
        a_base_d = a_base_q;
        x_cnt_d  = x_cnt_q;
        c_addr_d = c_addr_q;
        c_col_d  = c_col_q;
        c_grp_d  = c_grp_q;
        drain_d  = drain_q;
        o_idx_d  = o_idx_q;
        done_d   = 1'b0;
        unique case (state_q)
            StLoadA: if (in_hs) begin
                if (a_col_q == KW'(K - 1)) begin
                    a_col_d = '0;
                    if (a_lane_q == LW'(P - 1)) begin
                        a_lane_d = '0;
                        if (a_base_q == AW'(N - K)) begin
                            a_base_d = '0;
                            state_d  = StLoadX;
                        end else begin
                            a_base_d = a_base_q + AW'(K);
                        end
                    end else begin
                        a_lane_d = a_lane_q + LW'(1);
                    end
                end else begin
                    a_col_d = a_col_q + KW'(1);
                end
            end
            StLoadX: if (in_hs) begin
                if (x_cnt_q == KW'(K - 1)) begin
                    x_cnt_d = '0;
                    state_d = StCompute;
                end else begin
                    x_cnt_d = x_cnt_q + KW'(1);
                end
            end
            StCompute: begin
                c_addr_d = c_addr_q + AW'(1);
                if (c_col_q == KW'(K - 1)) begin
                    c_col_d = '0;
                    c_grp_d = c_grp_q + GW'(1);
                end else begin
                    c_col_d = c_col_q + KW'(1);
                end
                if (c_addr_q == AW'(N - 1)) begin
                    c_addr_d = '0;
                    c_col_d  = '0;
                    c_grp_d  = '0;
                    state_d  = StDrain;
                end
            end
            StDrain: begin
                if (drain_q == 3'(PIPE_DEPTH - 1)) begin
                    drain_d = '0;
                    state_d = StOutput;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            StOutput: if (out_hs) begin
                if (o_idx_q == KW'(K - 1)) begin
                    o_idx_d = '0;
                    done_d  = 1'b1;
                    state_d = mat_keep_i ? StLoadX : StLoadA;
                end else begin
                    o_idx_d = o_idx_q + KW'(1);
                end
            end
            default: state_d = StLoadA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StLoadA;
            a_col_q  <= '0;
            a_lane_q <= '0;
            a_base_q <= '0;
            x_cnt_q  <= '0;
            c_addr_q <= '0;
            c_col_q  <= '0;
            c_grp_q  <= '0;
            drain_q  <= '0;
            o_idx_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_col_q  <= a_col_d;
            a_lane_q <= a_lane_d;
            a_base_q <= a_base_d;
            x_cnt_q  <= x_cnt_d;
            c_addr_q <= c_addr_d;
            c_col_q  <= c_col_d;
            c_grp_q  <= c_grp_d;
            drain_q  <= drain_d;
            o_idx_q  <= o_idx_d;
            done_q   <= done_d;
        end
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        mvm_par_lane #(
            .K     (K),
            .P     (P),
            .B     (B),
            .ACC_W (ACC_W),
            .AW    (AW),
            .KW    (KW),
            .GW    (GW)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .a_we_i     ((state_q == StLoadA) && in_hs && (a_lane_q == LW'(l))),
            .a_waddr_i  (a_base_q + AW'(a_col_q)),
            .x_we_i     ((state_q == StLoadX) && in_hs),
            .x_waddr_i  (x_cnt_q),
            .wdata_i    (in_data_i),
            .rd_en_i    (state_q == StCompute),
            .rd_addr_i  (c_addr_q),
            .rd_col_i   (c_col_q),
            .rd_first_i (c_col_q == '0),
            .rd_last_i  (c_col_q == KW'(K - 1)),
            .rd_grp_i   (c_grp_q),
            .wb_valid_o (lane_wb[l]),
            .wb_grp_o   (lane_grp[l]),
            .wb_acc_o   (lane_acc[l])
        );
        // Lane l owns rows l, l+P, ...; group g maps to row g*P+l.
        assign wb_row[l] = KW'(int'(lane_grp[l]) * int'(P) + l);
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < P; l++) begin
            if (lane_wb[l]) y_q[wb_row[l]] <= lane_acc[l];
        end
    end

endmodule

// File: doc/mvm_par_engine.md
# mvm_par_engine

Parametrised matrix-vector multiply engine computing y = A·x for a signed K×K matrix and K-vector. It uses P parallel MAC lanes and valid/ready streaming on both load and result paths. It can keep a loaded matrix across multiple vector jobs. It is the drop-in successor to the single-MAC MVM generator output and sits between the host load/store stream and the result consumer.

## Interface
- K, 8, matrix/vector dimension; K ≥ 2.
- P, 2, parallel MAC lanes; K % P == 0 required (elaboration error otherwise).
- B, 8, input element width, signed.
- ACC_W, 2*B+$clog2(K), result width; derived, not overridden.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine accepts input word.
- in_data  in  B  signed element; matrix row-major, then vector.
- mat_keep  in  1  sampled at final output handshake; 1 = reuse matrix for next job.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  signed y[out_index].
- out_index  out  $clog2(K)  row index of out_data.
- busy  out  1  high in COMPUTE/DRAIN/OUTPUT.
- done  out  1  one-cycle pulse on final result handshake.

## Operation
- States: LOAD_A, LOAD_X, COMPUTE, DRAIN, OUTPUT. Reset enters LOAD_A.
- LOAD_A: in_ready=1. Each handshake writes A[r][c]. Row r goes to lane r%P, at slot (r/P)*K+c. After K*K handshakes, go to LOAD_X.
- LOAD_X: in_ready=1. The vector is broadcast to all lanes' X copies. After K handshakes, go to COMPUTE.
- COMPUTE: issues one read per cycle per lane for (K/P)*K cycles. Lane l accumulates rows l, l+P, …
- Accumulation on column 0 loads the product into acc (no clear bubble). Columns 1..K-1 add. Row groups run back-to-back.
- When column K-1 is accumulated, the lane writes its acc into Y[row].
- DRAIN: D cycles flushing the pipeline, then go to OUTPUT.
- OUTPUT: present Y[0..K-1] in order. out_data/out_index are held stable while out_valid && !out_ready.
- Last handshake: pulse done. Next state is LOAD_X if mat_keep=1, else LOAD_A.
- Arithmetic: B×B signed product, sign-extended to ACC_W. No overflow is possible; no saturation.
- in_ready=0 in COMPUTE/DRAIN/OUTPUT. in_valid is ignored there, and no state changes.
- mat_keep=1 on the first job after reset is still valid. A then holds undefined data, and the result is don't-care (not checked).
- Reset mid-operation: all outputs return to reset values and the state goes to LOAD_A. Memories are not cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_index=0, busy=0, done=0.
- Pipeline per lane: address issue → memory data (+1) → product register (+1) → accumulator (+1). D=3.
- Last vector handshake at edge t. First out_valid is high in cycle t+(K*K)/P+D.
- Result throughput is 1 per cycle when out_ready=1. Job throughput with mat_keep: K + (K*K)/P + D + K cycles.
- in_ready/out_valid are decoded from registered state only. There is no combinational in→out path.

## Configuration
- MVM_PIPE_MULT_EN defined: adds a second multiplier register stage (for high B). D=4, and all latencies grow by 1.
- Not defined: single product register, D=3. Functional results are identical in both cases.

## Structure
- Package mvm_par_pkg holds:
  - state enum mvm_state_t;
  - function acc_width(B,K);
  - localparam PIPE_DEPTH, set per MVM_PIPE_MULT_EN.
- Sub-module mvm_par_lane contains:
  - A bank (K*K/P words);
  - X copy (K words);
  - multiplier, pipeline registers and accumulator;
  - write-back strobe.
- The top-level holds the FSM, counters, Y register file and output mux.

## Test plan
- K=4,P=2,B=8, identity A, x=[1,2,3,4] → y=[1,2,3,4]. First out_valid exactly 11 cycles after the last x handshake (12 with macro).
- All A=-128, x=-128 → every y=65536. Checks that ACC_W=18 is enough without wrap.
- Random A/x with out_ready toggled randomly → out_data/out_index stable under stall. Results match the reference model; done pulses once.
- mat_keep=1, then second x=[0,0,0,1] → no matrix reload, y equals column 3 of A, in_ready high immediately in LOAD_X.
- reset asserted mid-COMPUTE → next cycle out_valid=0, busy=0, in_ready=1. A fresh job then computes correctly.
- in_valid held high during COMPUTE/OUTPUT with junk data → no effect on results or state.
